vga_capture: RTL and testbench

VGA_CAPTURE -- requirements
Module: vga_capture

---
 rtl/vga_capture.sv | 167 ++++++++++++++++
 tb/tb_vga_capture.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_capture.sv
// VGA input capture: recovers pixel coordinates from incoming hsync/vsync/rgb and locks to the expected timing.
// Latency: rgb pin to pix_data is 2 vga_clk cycles (one sync stage plus one output register).
// Backpressure: none; a pixel stream with no stall path, and pixels are only emitted while locked.
module vga_capture #(
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int H_VALID = 640,
  parameter int H_TOTAL = 800,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int V_VALID = 480,
  parameter int V_TOTAL = 525
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [15:0] rgb,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [15:0] pix_data,
  output logic        sof,
  output logic        eol,
  output logic        locked,
  output logic        err
);

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_MAX   = 11'd2047;
  localparam logic [10:0] H_START = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_END   = 11'(H_SYNC + H_BACK + H_VALID);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_MAX   = 10'd1023;
  localparam logic [9:0]  V_START = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]  V_END   = 10'(V_SYNC + V_BACK + V_VALID);
  localparam logic [9:0]  X_LAST  = 10'(H_VALID - 1);

  // Only hsync needs the second stage (edge detect); vsync and rgb are consumed at s1.
  logic        hs_s1_q, hs_s2_q, vs_s1_q;
  logic [15:0] rgb_s1_q;
  logic [10:0] h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic [1:0]  state_q, state_d;
  logic        vs_edge_q, vs_edge_d;   // vsync as seen at the previous hsync edge
  logic        first_q, first_d;       // next hsync edge has no valid line length behind it
  logic        lines_ok_q, lines_ok_d; // all line checks good since the last frame start
  logic        pix_valid_d, sof_d, eol_d, err_d;
  logic [9:0]  pix_x_d, pix_y_d;
  logic [15:0] pix_data_d;
  logic        pix_valid_q, sof_q, eol_q, err_q;
  logic [9:0]  pix_x_q, pix_y_q;
  logic [15:0] pix_data_q;

  logic h_edge, frame_start, line_bad, frame_good, is_locked, drop, active;

  // Timing detection and lock tracking for the current cycle.
  always_comb begin
    h_edge      = hs_s2_q & ~hs_s1_q;
    frame_start = h_edge & ~vs_s1_q & vs_edge_q;
    line_bad    = h_edge & ~first_q & (h_cnt_q != H_LAST);
    frame_good  = (v_cnt_q == V_LAST) & lines_ok_q & ~line_bad;
    is_locked   = (state_q == ST_LOCKED);
    // A single drop condition covers every reason for losing lock, so coincident causes give one err.
    drop        = is_locked & (line_bad | (frame_start & ~frame_good) | (h_cnt_q == H_MAX));
    active      = is_locked & ~drop &
                  (h_cnt_q >= H_START) & (h_cnt_q < H_END) &
                  (v_cnt_q >= V_START) & (v_cnt_q < V_END);
  end

  // Counters, check bookkeeping and the SEARCH/VERIFY/LOCKED sequencer.
  always_comb begin
    h_cnt_d    = (h_cnt_q == H_MAX) ? H_MAX : h_cnt_q + 11'd1;
    v_cnt_d    = v_cnt_q;
    vs_edge_d  = vs_edge_q;
    first_d    = first_q;
    lines_ok_d = lines_ok_q;
    state_d    = state_q;
    if (h_edge) begin
      h_cnt_d   = 11'd0;
      vs_edge_d = vs_s1_q;
      first_d   = 1'b0;
      if (frame_start)
        v_cnt_d = 10'd0;
      else if (v_cnt_q != V_MAX)
        v_cnt_d = v_cnt_q + 10'd1;
    end else if (state_q == ST_SEARCH) begin
      first_d = 1'b1;
    end
    if (frame_start)
      lines_ok_d = 1'b1;
    else if (line_bad)
      lines_ok_d = 1'b0;
    case (state_q)
      ST_SEARCH: if (frame_start) state_d = ST_VERIFY;
      ST_VERIFY: if (frame_start && frame_good) state_d = ST_LOCKED;
      ST_LOCKED: if (drop) state_d = ST_SEARCH;
      default:   state_d = ST_SEARCH;
    endcase
  end

  // Output stage: coordinates and data are forced to zero outside active pixels.
  always_comb begin
    pix_valid_d = active;
    pix_x_d     = active ? 10'(h_cnt_q - H_START) : 10'd0;
    pix_y_d     = active ? (v_cnt_q - V_START) : 10'd0;
    pix_data_d  = active ? rgb_s1_q : 16'd0;
    sof_d       = active & (pix_x_d == 10'd0) & (pix_y_d == 10'd0);
    eol_d       = active & (pix_x_d == X_LAST);
    err_d       = drop;
  end

  // All state, with asynchronous reset to the idle/search condition.
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      hs_s1_q     <= 1'b1;
      hs_s2_q     <= 1'b1;
      vs_s1_q     <= 1'b1;
      rgb_s1_q    <= 16'd0;
      h_cnt_q     <= 11'd0;
      v_cnt_q     <= 10'd0;
      state_q     <= ST_SEARCH;
      vs_edge_q   <= 1'b1;
      first_q     <= 1'b1;
      lines_ok_q  <= 1'b1;
      pix_valid_q <= 1'b0;
      pix_x_q     <= 10'd0;
      pix_y_q     <= 10'd0;
      pix_data_q  <= 16'd0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      hs_s1_q     <= hsync;
      hs_s2_q     <= hs_s1_q;
      vs_s1_q     <= vsync;
      rgb_s1_q    <= rgb;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      state_q     <= state_d;
      vs_edge_q   <= vs_edge_d;
      first_q     <= first_d;
      lines_ok_q  <= lines_ok_d;
      pix_valid_q <= pix_valid_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_data_q  <= pix_data_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
      err_q       <= err_d;
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_data  = pix_data_q;
  assign sof       = sof_q;
  assign eol       = eol_q;
  assign err       = err_q;
  assign locked    = is_locked;

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture using a reduced 32x16 timing so whole frames stay short.
// A reference generator drives hsync/vsync/rgb on the falling clock edge and samples outputs there.
// Expected counts, cycle offsets and pixel values are derived from the generator timing.
module tb_vga_capture;

  localparam int HS = 4;
  localparam int HB = 4;
  localparam int HV = 16;
  localparam int HT = 32;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int VV = 8;
  localparam int VT = 16;

  logic        vga_clk, sys_rst, hsync, vsync;
  logic [15:0] rgb;
  logic        pix_valid, sof, eol, locked, err;
  logic [9:0]  pix_x, pix_y;
  logic [15:0] pix_data;

  vga_capture #(
    .H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_TOTAL(VT)
  ) dut (
    .vga_clk(vga_clk), .sys_rst(sys_rst), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .sof(sof), .eol(eol), .locked(locked), .err(err)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lcyc [0:VT-1];
  int n_valid, n_eol, n_sof, n_err, n_valid_after_err;
  int sof_cyc, err_cyc, lock_cyc, drv00_cyc, last_eol;
  logic [15:0] sof_dat, last_dat;
  logic seen_err, prev_locked;
  int ex, ey;
  int n_pos_bad = 0;
  int n_dat_bad = 0;
  int n_idle_bad = 0;

  function automatic logic [15:0] pat(input int x, input int y);
    if (x == 0 && y == 0) return 16'hF800;
    if (x == HV-1 && y == VV-1) return 16'h001F;
    return {2'b01, y[3:0], x[9:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    n_valid = 0; n_eol = 0; n_sof = 0; n_err = 0; n_valid_after_err = 0;
    sof_cyc = -1; err_cyc = -1; lock_cyc = -1; last_eol = 0;
    sof_dat = 16'h0; last_dat = 16'h0; seen_err = 1'b0;
    ex = 0; ey = 0;
  endtask

  // Output monitor, called once per cycle on the falling edge.
  task automatic sample();
    if (err) begin
      n_err++; err_cyc = cyc; seen_err = 1'b1;
    end
    if (locked && !prev_locked) lock_cyc = cyc;
    prev_locked = locked;
    if (pix_valid) begin
      n_valid++;
      if (seen_err) n_valid_after_err++;
      if (int'(pix_x) != ex || int'(pix_y) != ey) n_pos_bad++;
      if (pix_data !== pat(int'(pix_x), int'(pix_y))) n_dat_bad++;
      if (sof) begin
        n_sof++; sof_cyc = cyc; sof_dat = pix_data;
        if (pix_x != 0 || pix_y != 0) n_pos_bad++;
      end
      if (eol) begin
        n_eol++;
        if (int'(pix_x) != HV-1) n_pos_bad++;
      end
      if (int'(pix_x) == HV-1 && int'(pix_y) == VV-1) begin
        last_dat = pix_data; last_eol = int'(eol);
      end
      ex++;
      if (ex == HV) begin ex = 0; ey++; end
      if (ey == VV) ey = 0;
    end else if (pix_x != 0 || pix_y != 0 || pix_data != 0 || sof || eol) begin
      n_idle_bad++;
    end
  endtask

  task automatic step(input logic hs, input logic vs, input logic [15:0] d);
    @(negedge vga_clk);
    sample();
    hsync = hs; vsync = vs; rgb = d;
    cyc++;
  endtask

  // One line: hsync low for the first HS pixels; column x sits at pixel HS+HB+1+x because
  // the counter restarts one cycle after the sync edge is seen at s1.
  task automatic gen_line(input int ly, input int len, input int rst_p);
    int x, y;
    logic [15:0] d;
    for (int p = 0; p < len; p++) begin
      if (p == rst_p) begin
        chk("rst_pre_valid", {31'd0, pix_valid}, 32'd1);
        sys_rst = 1'b1;
        #1;
        chk("rst_async_valid", {31'd0, pix_valid}, 32'd0);
        chk("rst_async_xy", {12'd0, pix_x, pix_y}, 32'd0);
        chk("rst_async_data", {16'd0, pix_data}, 32'd0);
        chk("rst_async_flags", {28'd0, sof, eol, locked, err}, 32'd0);
        #1;
        sys_rst = 1'b0;
      end
      x = p - (HS + HB + 1);
      y = ly - (VS + VB);
      if (x >= 0 && x < HV && y >= 0 && y < VV) d = pat(x, y);
      else d = 16'hA5A5;
      if (p == 0) lcyc[ly] = cyc;
      if (x == 0 && y == 0) drv00_cyc = cyc;
      step((p < HS) ? 1'b0 : 1'b1, (ly < VS) ? 1'b0 : 1'b1, d);
    end
  endtask

  task automatic gen_frame(input int nlines, input int short_ly, input int rst_ly, input int rst_p);
    for (int ly = 0; ly < nlines; ly++)
      gen_line(ly, (ly == short_ly) ? HT-1 : HT, (ly == rst_ly) ? rst_p : -1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 16'hA5A5);
  endtask

  initial begin
    sys_rst = 1'b1; hsync = 1'b1; vsync = 1'b1; rgb = 16'h0;
    prev_locked = 1'b0;
    clear_stats();
    idle(3);
    chk("reset_valid", {31'd0, pix_valid}, 32'd0);
    chk("reset_x", {22'd0, pix_x}, 32'd0);
    chk("reset_y", {22'd0, pix_y}, 32'd0);
    chk("reset_data", {16'd0, pix_data}, 32'd0);
    chk("reset_flags", {28'd0, sof, eol, locked, err}, 32'd0);
    sys_rst = 1'b0;
    idle(4);

    // Lock acquisition over three clean frames.
    clear_stats(); gen_frame(VT, -1, -1, -1);
    chk("f1_not_locked", {31'd0, locked}, 32'd0);
    chk("f1_no_err", n_err, 0);
    clear_stats(); gen_frame(VT, -1, -1, -1);
    chk("f2_lock_time", lock_cyc - lcyc[0], 2);
    chk("f2_locked", {31'd0, locked}, 32'd1);
    clear_stats(); gen_frame(VT, -1, -1, -1);
    chk("f3_valid_count", n_valid, HV*VV);
    chk("f3_eol_count", n_eol, VV);
    chk("f3_sof_count", n_sof, 1);
    chk("f3_no_err", n_err, 0);
    chk("f3_first_data", {16'd0, sof_dat}, 32'hF800);
    chk("f3_latency", sof_cyc - drv00_cyc, 2);
    chk("f3_last_data", {16'd0, last_dat}, 32'h001F);
    chk("f3_last_eol", last_eol, 1);

    // Short line (31 pixels) on line 6; detected at the start of line 7.
    clear_stats(); gen_frame(VT, 6, -1, -1);
    chk("short_err_count", n_err, 1);
    chk("short_err_time", err_cyc - lcyc[7], 2);
    chk("short_unlocked", {31'd0, locked}, 32'd0);
    chk("short_no_valid_after", n_valid_after_err, 0);

    // 15-line frame while verifying, then a good frame, then relock.
    clear_stats(); gen_frame(VT-1, -1, -1, -1);
    chk("vshort_no_valid", n_valid, 0);
    clear_stats(); gen_frame(VT, -1, -1, -1);
    chk("vshort_still_verify", {31'd0, locked}, 32'd0);
    chk("vshort_no_err", n_err, 0);
    chk("vshort_no_valid2", n_valid, 0);
    clear_stats(); gen_frame(VT, -1, -1, -1);
    chk("relock_time", lock_cyc - lcyc[0], 2);
    chk("relock_valid_count", n_valid, HV*VV);
    chk("relock_no_err", n_err, 0);

    // hsync stuck high until the line counter saturates.
    clear_stats(); gen_frame(3, -1, -1, -1); idle(2100);
    chk("stuck_err_count", n_err, 1);
    chk("stuck_err_time", err_cyc - lcyc[2], 2050);
    chk("stuck_unlocked", {31'd0, locked}, 32'd0);

    // Relock, then reset in the middle of an active line; relock needs two more frame starts.
    clear_stats(); gen_frame(VT, -1, -1, -1);
    clear_stats(); gen_frame(VT, -1, 6, 16);
    chk("postrst_unlocked", {31'd0, locked}, 32'd0);
    clear_stats(); gen_frame(VT, -1, -1, -1);
    chk("postrst_verify", {31'd0, locked}, 32'd0);
    clear_stats(); gen_frame(VT, -1, -1, -1);
    chk("postrst_lock_time", lock_cyc - lcyc[0], 2);
    chk("postrst_valid_count", n_valid, HV*VV);

    chk("pos_sequence", n_pos_bad, 0);
    chk("data_values", n_dat_bad, 0);
    chk("idle_zero", n_idle_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
